// File: rtl/logic_unit_driver.sv
// Request driver for a four-phase logic unit: buffers request vectors in a FIFO, issues one at a
// time, waits for the done low/high cycle and returns the result bit. Optional watchdog: LOGIC_UNIT_DRIVER_TIMEOUT_EN.
module logic_unit_driver #(
   parameter int WIDTH      = 64,
   parameter int DEPTH      = 4,
   parameter int TMO_CYCLES = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_vec,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] lu_req_vec,
   output logic             lu_valid,
   input  logic             lu_out,
   input  logic             lu_done,
   output logic             res_data,
   output logic             res_timeout,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             busy,
   output logic [2:0]       state_dbg
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // valid is held with stable data until that edge, and ready never depends on valid.

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      WAIT_LO = 3'd2,
      WAIT_HI = 3'd3,
      RESP    = 3'd4
   } state_t;

   state_t state, state_n;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic             empty, full, push, pop;
   logic             capture, tmo_fire, tmo_hit;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push  = in_valid && !full;
   assign pop   = (state == IDLE) && !empty && lu_done;

   assign in_ready  = !full;
   assign busy      = (state != IDLE) || !empty;
   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= in_vec;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

`ifdef LOGIC_UNIT_DRIVER_TIMEOUT_EN
   localparam int WDW = ($clog2(TMO_CYCLES + 1) > 8) ? $clog2(TMO_CYCLES + 1) : 8;
   localparam logic [WDW-1:0] WD_LIM = WDW'(TMO_CYCLES - 1);

   logic [WDW-1:0] wd_cnt;

   // Counts cycles elapsed since the issue strobe; zero outside ISSUE and the wait states.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt <= '0;
      end else if (state == ISSUE || state == WAIT_LO || state == WAIT_HI) begin
         wd_cnt <= wd_cnt + 1'b1;
      end else begin
         wd_cnt <= '0;
      end
   end

   assign tmo_hit = (state == WAIT_LO || state == WAIT_HI) && (wd_cnt >= WD_LIM);
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_n  = state;
      capture  = 1'b0;
      tmo_fire = 1'b0;
      case (state)
         IDLE: begin
            if (pop) state_n = ISSUE;
         end
         ISSUE: begin
            state_n = WAIT_LO;
         end
         WAIT_LO: begin
            if (tmo_hit) begin
               state_n  = RESP;
               tmo_fire = 1'b1;
            end else if (!lu_done) begin
               state_n = WAIT_HI;
            end
         end
         WAIT_HI: begin
            // A done seen in the same cycle as the timeout takes priority.
            if (lu_done) begin
               state_n = RESP;
               capture = 1'b1;
            end else if (tmo_hit) begin
               state_n  = RESP;
               tmo_fire = 1'b1;
            end
         end
         RESP: begin
            if (res_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   logic res_tmo_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         lu_valid   <= 1'b0;
         lu_req_vec <= '0;
         res_valid  <= 1'b0;
         res_data   <= 1'b0;
         res_tmo_q  <= 1'b0;
      end else begin
         state    <= state_n;
         lu_valid <= pop;
         if (pop) lu_req_vec <= mem[rd_ptr[AW-1:0]];
         if (capture) begin
            res_valid <= 1'b1;
            res_data  <= lu_out;
            res_tmo_q <= 1'b0;
         end else if (tmo_fire) begin
            res_valid <= 1'b1;
            res_data  <= 1'b0;
            res_tmo_q <= 1'b1;
         end else if (state == RESP && res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

`ifdef LOGIC_UNIT_DRIVER_TIMEOUT_EN
   assign res_timeout = res_tmo_q;
`else
   assign res_timeout = 1'b0;
   logic unused_tmo;
   assign unused_tmo = res_tmo_q;
`endif

endmodule
